// File: rtl/learning_output_port_lookup_pkg.sv
// Shared definitions for the learning output-port lookup stage.
//   - IOQ module header field positions
//   - Ethernet DA/SA slice positions and the group (multicast) bit index
//   - Parse FSM state encoding
//   - MAC table entry layout
//   - Small helpers for port bitmaps
package learning_output_port_lookup_pkg;

    localparam int unsigned DST_PORT_POS = 0;   // one-hot destination bitmap, 16 bits
    localparam int unsigned SRC_PORT_POS = 16;  // binary source port, 16 bits
    localparam int unsigned PORT_FIELD_W = 16;

    // First data word: DA in [63:16], SA[47:32] in [15:0].
    // Second data word: SA[31:0] in [63:32].
    localparam int unsigned DA_MSB    = 63;
    localparam int unsigned DA_LSB    = 16;
    localparam int unsigned SA_HI_MSB = 15;
    localparam int unsigned SA_HI_LSB = 0;
    localparam int unsigned SA_LO_MSB = 63;
    localparam int unsigned SA_LO_LSB = 32;
    localparam int unsigned MCAST_BIT = 40;

    typedef enum logic [1:0] {
        StHdrs,
        StSaLo,
        StPayload
    } parse_state_e;

    typedef struct packed {
        logic        valid;
        logic        hit;
        logic [47:0] mac;
        logic [3:0]  port;
    } mac_entry_t;

    function automatic logic [15:0] port_onehot(input logic [3:0] p);
        return 16'h0001 << p;
    endfunction

    // Bitmap of all MAC (even-numbered) queues below nq.
    function automatic logic [15:0] even_port_mask(input int unsigned nq);
        logic [15:0] m;
        m = '0;
        for (int unsigned i = 0; i < nq && i < 16; i += 2) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/learning_output_port_lookup_mac_learning_table.sv
// MAC learning table: fully associative CAM of TABLE_DEPTH entries.
// Optional aging is built when LEARNING_OUTPUT_PORT_LOOKUP_AGING_EN is defined.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   lookup_valid_i    - a lookup is being made this cycle (gates hit, marks entry hit when aging)
//   lookup_mac_i      - MAC to look up
//   lookup_hit_o      - lookup matched a valid entry
//   lookup_port_o     - port stored in the matching entry
//   learn_valid_i     - write the learn MAC/port into the table at the clock edge
//   learn_mac_i       - source MAC to learn
//   learn_port_i      - port the source MAC was seen on
module mac_learning_table
    import learning_output_port_lookup_pkg::*;
#(
    parameter int unsigned TABLE_DEPTH = 16,
    parameter int unsigned AGE_PERIOD  = 2**24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lookup_valid_i,
    input  logic [47:0] lookup_mac_i,
    output logic        lookup_hit_o,
    output logic [3:0]  lookup_port_o,
    input  logic        learn_valid_i,
    input  logic [47:0] learn_mac_i,
    input  logic [3:0]  learn_port_i
);

    localparam int unsigned IdxW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;

    mac_entry_t      table_q [TABLE_DEPTH];
    mac_entry_t      table_d [TABLE_DEPTH];
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] lk_idx;
    logic            ln_hit, ln_free;
    logic [IdxW-1:0] ln_hit_idx, ln_free_idx, ln_idx;

    // Descending scans so the lowest matching / lowest free index wins.
    always_comb begin
        lookup_hit_o = 1'b0;
        lk_idx       = '0;
        ln_hit       = 1'b0;
        ln_hit_idx   = '0;
        ln_free      = 1'b0;
        ln_free_idx  = '0;
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (lookup_valid_i && table_q[i].valid && table_q[i].mac == lookup_mac_i) begin
                lookup_hit_o = 1'b1;
                lk_idx       = IdxW'(i);
            end
            if (table_q[i].valid && table_q[i].mac == learn_mac_i) begin
                ln_hit     = 1'b1;
                ln_hit_idx = IdxW'(i);
            end
            if (!table_q[i].valid) begin
                ln_free     = 1'b1;
                ln_free_idx = IdxW'(i);
            end
        end
        lookup_port_o = table_q[lk_idx].port;
        ln_idx = ln_hit ? ln_hit_idx : (ln_free ? ln_free_idx : ptr_q);
    end

`ifdef LEARNING_OUTPUT_PORT_LOOKUP_AGING_EN
    logic [31:0] age_q;
    logic        age_wrap;
    assign age_wrap = (age_q == 32'(AGE_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) age_q <= '0;
        else       age_q <= age_wrap ? '0 : age_q + 32'd1;
    end
`endif

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            table_d[i] = table_q[i];
        end
`ifdef LEARNING_OUTPUT_PORT_LOOKUP_AGING_EN
        if (age_wrap) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                if (!table_q[i].hit) table_d[i].valid = 1'b0;
                table_d[i].hit = 1'b0;
            end
        end
        // A lookup in the sweep cycle only marks an entry that survived the sweep.
        if (lookup_hit_o) table_d[lk_idx].hit = table_d[lk_idx].valid;
`endif
        if (learn_valid_i) begin
            table_d[ln_idx].valid = 1'b1;
            table_d[ln_idx].mac   = learn_mac_i;
            table_d[ln_idx].port  = learn_port_i;
`ifdef LEARNING_OUTPUT_PORT_LOOKUP_AGING_EN
            table_d[ln_idx].hit   = 1'b1;
`endif
            // Power-of-two depth: the pointer wraps by overflow.
            if (!ln_hit && !ln_free) ptr_d = ptr_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TABLE_DEPTH; i++) table_q[i] <= '0;
            ptr_q <= '0;
        end else begin
            for (int i = 0; i < TABLE_DEPTH; i++) table_q[i] <= table_d[i];
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/learning_output_port_lookup.sv
// Learning output-port lookup stage: learns source MACs per MAC port, looks up the
// destination MAC and rewrites the IOQ header dst bitmap (unicast / flood / filter).
// Even queues are MAC ports, odd queues are CPU ports (CPU n -> MAC n-1).
// Optional aging: define LEARNING_OUTPUT_PORT_LOOKUP_AGING_EN.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_data_i/in_ctrl_i  - input word and ctrl, qualified by in_wr_i
//   in_rdy_o             - upstream may write this cycle
//   out_data_o/out_ctrl_o- output word and ctrl, qualified by out_wr_o (registered)
//   out_rdy_i            - downstream may accept
module learning_output_port_lookup
    import learning_output_port_lookup_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH         = 64,
    parameter int unsigned           CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int unsigned           NUM_OUTPUT_QUEUES  = 8,
    parameter int unsigned           TABLE_DEPTH        = 16,
    parameter int unsigned           FIFO_DEPTH_BITS    = 3,
    parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = 8'hFF,
    parameter int unsigned           AGE_PERIOD         = 2**24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_i,
    input  logic                  in_wr_i,
    output logic                  in_rdy_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CTRL_WIDTH-1:0] out_ctrl_o,
    output logic                  out_wr_o,
    input  logic                  out_rdy_i
);

    localparam int unsigned FifoDepth = 2**FIFO_DEPTH_BITS;
    localparam int unsigned WordW     = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [FIFO_DEPTH_BITS:0] FifoNearlyFull = (FIFO_DEPTH_BITS+1)'(FifoDepth - 1);
    localparam logic [2:0]  DecNearlyFull = 3'd3;
    localparam logic [15:0] EvenMask      = even_port_mask(NUM_OUTPUT_QUEUES);

    // ---------------- parse side ----------------
    parse_state_e state_q, state_d;
    logic [47:0] da_q, da_d;
    logic [15:0] sa_hi_q, sa_hi_d;
    logic [31:0] sa_lo_q, sa_lo_d;
    logic [3:0]  src_q, src_d;
    logic        dec_pend_q, dec_pend_d;     // DA captured last cycle: decide now
    logic        learn_pend_q, learn_pend_d; // SA completed last cycle: learn now

    always_comb begin
        state_d      = state_q;
        da_d         = da_q;
        sa_hi_d      = sa_hi_q;
        sa_lo_d      = sa_lo_q;
        src_d        = src_q;
        dec_pend_d   = 1'b0;
        learn_pend_d = 1'b0;
        if (in_wr_i) begin
            unique case (state_q)
                StHdrs: begin
                    if (in_ctrl_i == IO_QUEUE_STAGE_NUM) begin
                        src_d = in_data_i[SRC_PORT_POS +: 4];
                    end else if (in_ctrl_i == '0) begin
                        da_d       = in_data_i[DA_MSB:DA_LSB];
                        sa_hi_d    = in_data_i[SA_HI_MSB:SA_HI_LSB];
                        dec_pend_d = 1'b1;
                        state_d    = StSaLo;
                    end
                end
                StSaLo: begin
                    sa_lo_d = in_data_i[SA_LO_MSB:SA_LO_LSB];
                    if (in_ctrl_i == '0) begin
                        learn_pend_d = !src_q[0] && !sa_hi_q[MCAST_BIT-32];
                        state_d      = StPayload;
                    end else begin
                        state_d = StHdrs;  // runt: no learning
                    end
                end
                StPayload: if (in_ctrl_i != '0) state_d = StHdrs;
                default:   state_d = StHdrs;
            endcase
        end
    end

    // ---------------- table and decision ----------------
    logic        lk_hit;
    logic [3:0]  lk_port;
    logic [15:0] dec_dst;

    mac_learning_table #(
        .TABLE_DEPTH (TABLE_DEPTH),
        .AGE_PERIOD  (AGE_PERIOD)
    ) u_table (
        .clk            (clk),
        .reset          (reset),
        .lookup_valid_i (dec_pend_q && !src_q[0]),
        .lookup_mac_i   (da_q),
        .lookup_hit_o   (lk_hit),
        .lookup_port_o  (lk_port),
        .learn_valid_i  (learn_pend_q),
        .learn_mac_i    ({sa_hi_q, sa_lo_q}),
        .learn_port_i   (src_q)
    );

    always_comb begin
        dec_dst = '0;
        if (src_q[0])                    dec_dst = port_onehot(src_q - 4'd1);
        else if (da_q[MCAST_BIT] || !lk_hit) dec_dst = EvenMask & ~port_onehot(src_q);
        else if (lk_port != src_q)       dec_dst = port_onehot(lk_port);
    end

    // ---------------- data FIFO ----------------
    logic [WordW-1:0]           fifo_mem_q [FifoDepth];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_BITS:0]   fifo_cnt_q, fifo_cnt_d;
    logic [WordW-1:0]           head_word;
    logic [CTRL_WIDTH-1:0]      head_ctrl;
    logic                       head_is_ioq, fifo_empty, fifo_rd;

    // ---------------- decision FIFO (4 deep) ----------------
    logic [15:0] dec_mem_q [4];
    logic [1:0]  dec_wr_ptr_q, dec_wr_ptr_d, dec_rd_ptr_q, dec_rd_ptr_d;
    logic [2:0]  dec_cnt_q, dec_cnt_d;
    logic        dec_empty, dec_pop;

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
    logic                  out_wr_q;

    assign head_word   = fifo_mem_q[rd_ptr_q];
    assign head_ctrl   = head_word[WordW-1 -: CTRL_WIDTH];
    assign head_is_ioq = head_ctrl == IO_QUEUE_STAGE_NUM;
    assign fifo_empty  = fifo_cnt_q == '0;
    assign dec_empty   = dec_cnt_q == '0;
    // A header may not leave before its decision exists.
    assign fifo_rd     = out_rdy_i && !fifo_empty && !(head_is_ioq && dec_empty);
    assign dec_pop     = fifo_rd && head_is_ioq;
    assign in_rdy_o    = !(fifo_cnt_q >= FifoNearlyFull) && !(dec_cnt_q >= DecNearlyFull);

    always_comb begin
        wr_ptr_d     = wr_ptr_q + FIFO_DEPTH_BITS'(in_wr_i);
        rd_ptr_d     = rd_ptr_q + FIFO_DEPTH_BITS'(fifo_rd);
        fifo_cnt_d   = fifo_cnt_q;
        unique case ({in_wr_i, fifo_rd})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        dec_wr_ptr_d = dec_wr_ptr_q + 2'(dec_pend_q);
        dec_rd_ptr_d = dec_rd_ptr_q + 2'(dec_pop);
        unique case ({dec_pend_q, dec_pop})
            2'b10:   dec_cnt_d = dec_cnt_q + 3'd1;
            2'b01:   dec_cnt_d = dec_cnt_q - 3'd1;
            default: dec_cnt_d = dec_cnt_q;
        endcase
        out_data_d = out_data_q;
        out_ctrl_d = out_ctrl_q;
        if (fifo_rd) begin
            out_ctrl_d = head_ctrl;
            out_data_d = head_word[DATA_WIDTH-1:0];
            if (head_is_ioq) out_data_d[DST_PORT_POS +: PORT_FIELD_W] = dec_mem_q[dec_rd_ptr_q];
        end
    end

    // Storage arrays need no reset: occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (in_wr_i)    fifo_mem_q[wr_ptr_q]    <= {in_ctrl_i, in_data_i};
        if (dec_pend_q) dec_mem_q[dec_wr_ptr_q] <= dec_dst;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StHdrs;
            da_q         <= '0;
            sa_hi_q      <= '0;
            sa_lo_q      <= '0;
            src_q        <= '0;
            dec_pend_q   <= 1'b0;
            learn_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            dec_wr_ptr_q <= '0;
            dec_rd_ptr_q <= '0;
            dec_cnt_q    <= '0;
            out_data_q   <= '0;
            out_ctrl_q   <= '0;
            out_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            da_q         <= da_d;
            sa_hi_q      <= sa_hi_d;
            sa_lo_q      <= sa_lo_d;
            src_q        <= src_d;
            dec_pend_q   <= dec_pend_d;
            learn_pend_q <= learn_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            dec_wr_ptr_q <= dec_wr_ptr_d;
            dec_rd_ptr_q <= dec_rd_ptr_d;
            dec_cnt_q    <= dec_cnt_d;
            out_data_q   <= out_data_d;
            out_ctrl_q   <= out_ctrl_d;
            out_wr_q     <= fifo_rd;
        end
    end

    assign out_data_o = out_data_q;
    assign out_ctrl_o = out_ctrl_q;
    assign out_wr_o   = out_wr_q;

endmodule
